// File: rtl/comp_unit_pkg.sv
// Shared definitions for the parametrised computational unit: ALU function
// codes, data-bus source codes, write-enable bit positions and default widths.
package comp_unit_pkg;

   localparam int unsigned DEFAULT_DW    = 4;
   localparam int unsigned DEFAULT_CNT_W = 3;

   // alu_func[2:0]; alu_func[3] turns NEG and NOT into a NOP
   typedef enum logic [2:0] {
      ALU_NEG  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_ADD  = 3'd2,
      ALU_MULH = 3'd3,
      ALU_MULL = 3'd4,
      ALU_XOR  = 3'd5,
      ALU_AND  = 3'd6,
      ALU_NOT  = 3'd7
   } alu_op_e;

   // data_bus source codes; 10..15 drive zero
   localparam logic [3:0] SRC_X0     = 4'd0;
   localparam logic [3:0] SRC_X1     = 4'd1;
   localparam logic [3:0] SRC_Y0     = 4'd2;
   localparam logic [3:0] SRC_Y1     = 4'd3;
   localparam logic [3:0] SRC_R      = 4'd4;
   localparam logic [3:0] SRC_M      = 4'd5;
   localparam logic [3:0] SRC_I      = 4'd6;
   localparam logic [3:0] SRC_DM     = 4'd7;
   localparam logic [3:0] SRC_PM     = 4'd8;
   localparam logic [3:0] SRC_I_PINS = 4'd9;

   // reg_en bit positions
   localparam int unsigned REN_W      = 9;
   localparam int unsigned REN_X0     = 0;
   localparam int unsigned REN_X1     = 1;
   localparam int unsigned REN_Y0     = 2;
   localparam int unsigned REN_Y1     = 3;
   localparam int unsigned REN_R      = 4;
   localparam int unsigned REN_M      = 5;
   localparam int unsigned REN_I      = 6;
   localparam int unsigned REN_UNUSED = 7;
   localparam int unsigned REN_O_REG  = 8;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier, one partial product per clock.
// Ports: start (accepted only when idle), a/b operands latched on start,
// busy high for exactly DW cycles, done (combinational) marks the final step
// edge, product (combinational) is the accumulator value written on that edge.
module seq_multiplier #(
   parameter int unsigned DW    = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic            busy,
   output logic            done,
   output logic [2*DW-1:0] product
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [2*DW-1:0]     acc_q, acc_d;
   logic [2*DW-1:0]     mcand_q, mcand_d;
   logic [DW-1:0]       mplier_q, mplier_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                last_c;

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next state: latch on start, then add the shifted multiplicand per set multiplier bit
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      done     = 1'b0;
      last_c   = (cnt_q == CNT_W'(DW - 1));
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               acc_d    = '0;
               mcand_d  = {{DW{1'b0}}, a};
               mplier_d = b;
               cnt_d    = '0;
            end
         end
         S_RUN: begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_c) begin
               state_d = S_IDLE;
               done    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy    = (state_q == S_RUN);
   // Final sum is forwarded so the consumer captures it on the last step edge
   assign product = acc_d;

endmodule

// File: rtl/param_computational_unit.sv
// Parametrised nibble-processor datapath: register file (x0,x1,y0,y1,m,i,
// o_reg,r), data-bus source mux, ALU with carry/neg/zero flags and a multiply
// that stalls the controller through busy.
// Ports: clk, reset_n; controls source_sel, alu_func, x_sel, y_sel, i_sel,
// reg_en; data inputs pm_data, dm, i_pins; outputs data_bus (combinational
// mux), register contents, r_eq_0, carry, neg, busy.
// Build option COMP_UNIT_FAST_MUL_EN: single-cycle combinational multiply with
// busy tied low; undefined (default) uses the iterative seq_multiplier.
module param_computational_unit
   import comp_unit_pkg::*;
#(
   parameter int unsigned DW    = DEFAULT_DW,
   parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [3:0]       source_sel,
   input  logic [DW-1:0]    pm_data,
   input  logic [DW-1:0]    dm,
   input  logic [DW-1:0]    i_pins,
   input  logic [3:0]       alu_func,
   input  logic             x_sel,
   input  logic             y_sel,
   input  logic             i_sel,
   input  logic [REN_W-1:0] reg_en,
   output logic [DW-1:0]    data_bus,
   output logic [DW-1:0]    x0,
   output logic [DW-1:0]    x1,
   output logic [DW-1:0]    y0,
   output logic [DW-1:0]    y1,
   output logic [DW-1:0]    m,
   output logic [DW-1:0]    i,
   output logic [DW-1:0]    o_reg,
   output logic [DW-1:0]    r,
   output logic             r_eq_0,
   output logic             carry,
   output logic             neg,
   output logic             busy
);

   logic [DW-1:0]   x0_q, x1_q, y0_q, y1_q, m_q, i_q, o_reg_q, r_q;
   logic [DW-1:0]   i_d, r_d;
   logic            r_eq_0_q, r_eq_0_d, carry_q, carry_d, neg_q, neg_d;
   logic [DW-1:0]   x_c, y_c;
   logic [DW:0]     ext_c;
   logic            r_wr_c;
   logic            nop_c;
   alu_op_e         op_c;
   logic            mul_busy;
   logic [2*DW-1:0] mul_prod_c;
   logic            unused_ok_c;

   assign unused_ok_c = reg_en[REN_UNUSED];

   assign op_c  = alu_op_e'(alu_func[2:0]);
   assign nop_c = alu_func[3];
   assign x_c   = x_sel ? x1_q : x0_q;
   assign y_c   = y_sel ? y1_q : y0_q;

`ifdef COMP_UNIT_FAST_MUL_EN
   assign mul_busy   = 1'b0;
   assign mul_prod_c = {{DW{1'b0}}, x_c} * {{DW{1'b0}}, y_c};
`else
   logic mul_start_c, mul_done_c, mul_hi_q, mul_hi_d;

   seq_multiplier #(
      .DW    (DW),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mul_start_c),
      .a       (x_c),
      .b       (y_c),
      .busy    (mul_busy),
      .done    (mul_done_c),
      .product (mul_prod_c)
   );

   // Which product half lands in r is fixed at request time
   always_comb begin
      mul_hi_d = mul_hi_q;
      if (mul_start_c) mul_hi_d = (op_c == ALU_MULH);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) mul_hi_q <= 1'b0;
      else          mul_hi_q <= mul_hi_d;
   end
`endif

   // Data-bus source mux; r shows its current (pre-multiply) value while busy
   always_comb begin
      data_bus = '0;
      case (source_sel)
         SRC_X0:     data_bus = x0_q;
         SRC_X1:     data_bus = x1_q;
         SRC_Y0:     data_bus = y0_q;
         SRC_Y1:     data_bus = y1_q;
         SRC_R:      data_bus = r_q;
         SRC_M:      data_bus = m_q;
         SRC_I:      data_bus = i_q;
         SRC_DM:     data_bus = dm;
         SRC_PM:     data_bus = pm_data;
         SRC_I_PINS: data_bus = i_pins;
         default:    data_bus = '0;
      endcase
   end

   // ALU result, carry and flag next-state; r requests are dropped while busy
   always_comb begin
      r_d     = r_q;
      carry_d = carry_q;
      r_wr_c  = 1'b0;
      ext_c   = '0;
`ifndef COMP_UNIT_FAST_MUL_EN
      mul_start_c = 1'b0;
`endif
      if (reg_en[REN_R] && !mul_busy) begin
         case (op_c)
            ALU_NEG: begin
               if (!nop_c) begin
                  r_d     = -x_c;
                  carry_d = |x_c;
                  r_wr_c  = 1'b1;
               end
            end
            ALU_SUB: begin
               ext_c   = {1'b0, x_c} - {1'b0, y_c};
               r_d     = ext_c[DW-1:0];
               carry_d = ext_c[DW];
               r_wr_c  = 1'b1;
            end
            ALU_ADD: begin
               ext_c   = {1'b0, x_c} + {1'b0, y_c};
               r_d     = ext_c[DW-1:0];
               carry_d = ext_c[DW];
               r_wr_c  = 1'b1;
            end
            ALU_MULH, ALU_MULL: begin
`ifdef COMP_UNIT_FAST_MUL_EN
               r_d    = (op_c == ALU_MULH) ? mul_prod_c[2*DW-1:DW] : mul_prod_c[DW-1:0];
               r_wr_c = 1'b1;
`else
               mul_start_c = 1'b1;
`endif
            end
            ALU_XOR: begin
               r_d    = x_c ^ y_c;
               r_wr_c = 1'b1;
            end
            ALU_AND: begin
               r_d    = x_c & y_c;
               r_wr_c = 1'b1;
            end
            ALU_NOT: begin
               if (!nop_c) begin
                  r_d    = ~x_c;
                  r_wr_c = 1'b1;
               end
            end
            default: r_wr_c = 1'b0;
         endcase
      end
`ifndef COMP_UNIT_FAST_MUL_EN
      // Completion cannot coincide with a new ALU write: requests need !busy
      if (mul_done_c) begin
         r_d    = mul_hi_q ? mul_prod_c[2*DW-1:DW] : mul_prod_c[DW-1:0];
         r_wr_c = 1'b1;
      end
`endif
      r_eq_0_d = r_wr_c ? (r_d == '0) : r_eq_0_q;
      neg_d    = r_wr_c ? r_d[DW-1]   : neg_q;
      i_d      = i_q;
      if (reg_en[REN_I]) i_d = i_sel ? (i_q + m_q) : data_bus;
   end

   // Register file and flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x0_q     <= '0;
         x1_q     <= '0;
         y0_q     <= '0;
         y1_q     <= '0;
         m_q      <= '0;
         i_q      <= '0;
         o_reg_q  <= '0;
         r_q      <= '0;
         r_eq_0_q <= 1'b1;
         carry_q  <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         if (reg_en[REN_X0])    x0_q    <= data_bus;
         if (reg_en[REN_X1])    x1_q    <= data_bus;
         if (reg_en[REN_Y0])    y0_q    <= data_bus;
         if (reg_en[REN_Y1])    y1_q    <= data_bus;
         if (reg_en[REN_M])     m_q     <= data_bus;
         if (reg_en[REN_O_REG]) o_reg_q <= data_bus;
         i_q      <= i_d;
         r_q      <= r_d;
         r_eq_0_q <= r_eq_0_d;
         carry_q  <= carry_d;
         neg_q    <= neg_d;
      end
   end

   assign x0     = x0_q;
   assign x1     = x1_q;
   assign y0     = y0_q;
   assign y1     = y1_q;
   assign m      = m_q;
   assign i      = i_q;
   assign o_reg  = o_reg_q;
   assign r      = r_q;
   assign r_eq_0 = r_eq_0_q;
   assign carry  = carry_q;
   assign neg    = neg_q;
   assign busy   = mul_busy;

endmodule

// File: tb/tb_param_computational_unit.sv
// Self-checking bench for param_computational_unit: a scoreboard of expected
// {r, carry, r_eq_0, neg} entries, pushed when an ALU/multiply request is
// driven and popped when the DUT writes r. Honours COMP_UNIT_FAST_MUL_EN.
module tb_param_computational_unit;
   import comp_unit_pkg::*;

   localparam int unsigned DW = 4;
`ifdef COMP_UNIT_FAST_MUL_EN
   localparam int EXP_BUSY = 0;
`else
   localparam int EXP_BUSY = DW;
`endif

   typedef struct packed {
      logic [DW-1:0] r;
      logic          carry;
      logic          zero;
      logic          neg;
   } exp_t;

   logic             clk, reset_n;
   logic [3:0]       source_sel;
   logic [DW-1:0]    pm_data, dm, i_pins;
   logic [3:0]       alu_func;
   logic             x_sel, y_sel, i_sel;
   logic [REN_W-1:0] reg_en;
   logic [DW-1:0]    data_bus, x0, x1, y0, y1, m, i_val, o_reg, r;
   logic             r_eq_0, carry, neg, busy;

   exp_t             exp_q[$];
   exp_t             mst;
   exp_t             got, e;
   int               checks = 0;
   int               errors = 0;
   logic [DW-1:0]    bx0, bx1, by0, by1, bm, bi, bo;

   param_computational_unit #(.DW(DW), .CNT_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .source_sel(source_sel), .pm_data(pm_data),
      .dm(dm), .i_pins(i_pins), .alu_func(alu_func), .x_sel(x_sel), .y_sel(y_sel),
      .i_sel(i_sel), .reg_en(reg_en), .data_bus(data_bus), .x0(x0), .x1(x1),
      .y0(y0), .y1(y1), .m(m), .i(i_val), .o_reg(o_reg), .r(r), .r_eq_0(r_eq_0),
      .carry(carry), .neg(neg), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU built from integer arithmetic
   function automatic exp_t model(input logic [3:0] f, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, input exp_t prev);
      exp_t        res;
      int unsigned av, bv, t, modv;
      res  = prev;
      av   = a;
      bv   = b;
      modv = 1 << DW;
      if (f[3] && (f[2:0] == 3'd0 || f[2:0] == 3'd7)) return prev;
      case (f[2:0])
         3'd0: begin res.r = DW'((modv - av) % modv); res.carry = (av != 0); end
         3'd1: begin res.r = DW'((av + modv - bv) % modv); res.carry = (av < bv); end
         3'd2: begin t = av + bv; res.r = DW'(t % modv); res.carry = (t >= modv); end
         3'd3: begin t = av * bv; res.r = DW'(t / modv); end
         3'd4: begin t = av * bv; res.r = DW'(t % modv); end
         3'd5: res.r = a ^ b;
         3'd6: res.r = a & b;
         default: res.r = ~a;
      endcase
      res.zero = (res.r == '0);
      res.neg  = res.r[DW-1];
      return res;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      reg_en     = '0;
      alu_func   = 4'b1000;
      source_sel = 4'hF;
      x_sel      = 1'b0;
      y_sel      = 1'b0;
      i_sel      = 1'b0;
   endtask

   task automatic load_reg(input int unsigned idx, input logic [DW-1:0] v);
      source_sel  = SRC_PM;
      pm_data     = v;
      i_sel       = 1'b0;
      reg_en      = '0;
      reg_en[idx] = 1'b1;
      cyc();
      reg_en = '0;
      case (idx)
         REN_X0: bx0 = v;
         REN_X1: bx1 = v;
         REN_Y0: by0 = v;
         REN_Y1: by1 = v;
         REN_M:  bm  = v;
         REN_I:  bi  = v;
         default: ;
      endcase
   endtask

   // Drives one ALU request for a cycle and queues its expected outcome
   task automatic issue_alu(input logic [3:0] f, input logic xs, input logic ys);
      exp_t ex;
      ex = model(f, xs ? bx1 : bx0, ys ? by1 : by0, mst);
      exp_q.push_back(ex);
      mst        = ex;
      alu_func   = f;
      x_sel      = xs;
      y_sel      = ys;
      reg_en     = '0;
      reg_en[REN_R] = 1'b1;
      cyc();
      reg_en = '0;
   endtask

   task automatic reset_model();
      exp_q.delete();
      mst = '{r: '0, carry: 1'b0, zero: 1'b1, neg: 1'b0};
      {bx0, bx1, by0, by1, bm, bi, bo} = '0;
   endtask

   task automatic test_reset();
      drive_idle();
      reset_n = 1'b0;
      cyc();
      cyc();
      reset_n = 1'b1;
      load_reg(REN_X0, 4'h3);
      load_reg(REN_Y1, 4'h5);
      alu_func = {1'b0, ALU_MULH};
      y_sel    = 1'b1;
      reg_en   = '0;
      reg_en[REN_R] = 1'b1;
      cyc();
      drive_idle();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({x0, x1, y0, y1, m, i_val, o_reg, r} !== '0) begin
         errors++;
         $display("FAIL reset_regs: got %h expected 0", {x0, x1, y0, y1, m, i_val, o_reg, r});
      end
      checks++;
      if ({r_eq_0, carry, neg, busy} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 1000", {r_eq_0, carry, neg, busy});
      end
      cyc();
      #2;
      reset_n = 1'b1;
      reset_model();
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++;
         if ({x0, x1, y0, y1, m, i_val, o_reg, r, r_eq_0, carry, neg, busy} !== {{(8*DW){1'b0}}, 4'b1000}) begin
            errors++;
            $display("FAIL reset_hold%0d: got %h/%b expected 0/1000", k,
                     {x0, x1, y0, y1, m, i_val, o_reg, r}, {r_eq_0, carry, neg, busy});
         end
      end
   endtask

   task automatic test_alu();
      load_reg(REN_X0, 4'h9);
      load_reg(REN_Y0, 4'h8);
      issue_alu({1'b0, ALU_ADD}, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = {r, carry, r_eq_0, neg};
      checks++;
      if (got !== e) begin errors++; $display("FAIL add_sb: got %h expected %h", got, e); end
      checks++;
      if ({r, carry, r_eq_0} !== {4'h1, 1'b1, 1'b0}) begin
         errors++; $display("FAIL add_9_8: got %h expected 0x1/c1/z0", {r, carry, r_eq_0});
      end
      load_reg(REN_X0, 4'h3);
      load_reg(REN_Y0, 4'h5);
      issue_alu({1'b0, ALU_SUB}, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = {r, carry, r_eq_0, neg};
      checks++;
      if (got !== e) begin errors++; $display("FAIL sub_sb: got %h expected %h", got, e); end
      checks++;
      if ({r, carry, neg} !== {4'hE, 1'b1, 1'b1}) begin
         errors++; $display("FAIL sub_3_5: got %h expected 0xE/c1/n1", {r, carry, neg});
      end
      load_reg(REN_X1, 4'hA);
      load_reg(REN_Y1, 4'h6);
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: issue_alu({1'b0, ALU_XOR}, 1'b1, 1'b1);
            1: issue_alu({1'b0, ALU_AND}, 1'b1, 1'b1);
            default: issue_alu({1'b0, ALU_NOT}, 1'b1, 1'b0);
         endcase
         e = exp_q.pop_front(); got = {r, carry, r_eq_0, neg};
         checks++;
         if (got !== e) begin errors++; $display("FAIL logic_op%0d: got %h expected %h", k, got, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] ops [6];
      logic [3:0] f;
      ops = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd7};
      load_reg(REN_X0, 4'($urandom_range(0, 15)));
      load_reg(REN_X1, 4'($urandom_range(0, 15)));
      load_reg(REN_Y0, 4'($urandom_range(0, 15)));
      load_reg(REN_Y1, 4'($urandom_range(0, 15)));
      for (int k = 0; k < 12; k++) begin
         f = {1'($urandom_range(0, 1)), ops[$urandom_range(0, 5)]};
         issue_alu(f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         e = exp_q.pop_front(); got = {r, carry, r_eq_0, neg};
         checks++;
         if (got !== e) begin
            errors++; $display("FAIL b2b%0d func %h: got %h expected %h", k, f, got, e);
         end
      end
   endtask

   // Multiply x0*y1; while busy, probe r/data_bus, clobber x0 and request an ADD
   task automatic run_mul(input logic [3:0] f, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] want);
      exp_t old, ex;
      int   nbusy;
      load_reg(REN_X0, a);
      load_reg(REN_Y1, b);
      old = mst;
      ex  = model(f, a, b, mst);
      exp_q.push_back(ex);
      mst        = ex;
      alu_func   = f;
      x_sel      = 1'b0;
      y_sel      = 1'b1;
      source_sel = SRC_R;
      reg_en     = '0;
      reg_en[REN_R] = 1'b1;
      cyc();
      reg_en = '0;
      nbusy  = 0;
      while (busy === 1'b1 && nbusy < 20) begin
         nbusy++;
         if (nbusy == 1) begin
            checks++;
            if (data_bus !== old.r || r !== old.r) begin
               errors++;
               $display("FAIL mul_old_r: got bus %h r %h expected %h", data_bus, r, old.r);
            end
            source_sel = SRC_PM;
            pm_data    = ~a;
            alu_func   = {1'b0, ALU_ADD};
            reg_en     = '0;
            reg_en[REN_X0] = 1'b1;
            reg_en[REN_R]  = 1'b1;
            bx0 = ~a;
         end
         cyc();
      end
      reg_en = '0;
      checks++;
      if (nbusy != EXP_BUSY) begin
         errors++; $display("FAIL mul_busy_cycles: got %0d expected %0d", nbusy, EXP_BUSY);
      end
      e = exp_q.pop_front(); got = {r, carry, r_eq_0, neg};
      checks++;
      if (got !== e) begin errors++; $display("FAIL mul_sb f%h: got %h expected %h", f, got, e); end
      checks++;
      if (r !== want) begin errors++; $display("FAIL mul_const f%h: got %h expected %h", f, r, want); end
      checks++;
      if (x0 !== bx0) begin errors++; $display("FAIL mul_x0_write: got %h expected %h", x0, bx0); end
   endtask

   task automatic test_mul();
      run_mul({1'b0, ALU_MULH}, 4'hF, 4'hF, 4'hE);
      run_mul({1'b0, ALU_MULL}, 4'hF, 4'hF, 4'h1);
      run_mul({1'b0, ALU_MULH}, 4'h7, 4'h6, 4'h2);
      run_mul({1'b0, ALU_MULL}, 4'h7, 4'h6, 4'hA);
      run_mul({1'b0, ALU_MULL}, 4'h0, 4'h9, 4'h0);
   endtask

   task automatic test_nop();
      load_reg(REN_X0, 4'h3);
      load_reg(REN_Y0, 4'h5);
      issue_alu({1'b0, ALU_SUB}, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = {r, carry, r_eq_0, neg};
      checks++;
      if (got !== e) begin errors++; $display("FAIL nop_setup: got %h expected %h", got, e); end
      load_reg(REN_X0, 4'h0);
      issue_alu(4'b1000, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = {r, carry, r_eq_0, neg};
      checks++;
      if (got !== e || {r, carry, r_eq_0} !== {4'hE, 1'b1, 1'b0}) begin
         errors++; $display("FAIL nop_neg: got %h expected %h", got, e);
      end
      issue_alu(4'b1111, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = {r, carry, r_eq_0, neg};
      checks++;
      if (got !== e) begin errors++; $display("FAIL nop_not: got %h expected %h", got, e); end
      issue_alu({1'b0, ALU_NEG}, 1'b0, 1'b0);
      e = exp_q.pop_front(); got = {r, carry, r_eq_0, neg};
      checks++;
      if (got !== e || {r, carry, r_eq_0} !== {4'h0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL neg_zero: got %h expected %h", got, e);
      end
   endtask

   task automatic test_index();
      load_reg(REN_M, 4'h3);
      load_reg(REN_I, 4'hE);
      i_sel  = 1'b1;
      reg_en = '0;
      reg_en[REN_I] = 1'b1;
      cyc();
      checks++;
      if (i_val !== 4'h1) begin errors++; $display("FAIL i_wrap: got %h expected 1", i_val); end
      cyc();
      checks++;
      if (i_val !== 4'h4) begin errors++; $display("FAIL i_step: got %h expected 4", i_val); end
      reg_en = '0;
      i_sel  = 1'b0;
      bi     = 4'h4;
   endtask

   task automatic test_bus();
      logic [DW-1:0] want;
      load_reg(REN_X0, 4'h1);
      load_reg(REN_X1, 4'h2);
      load_reg(REN_Y0, 4'h3);
      load_reg(REN_Y1, 4'h4);
      load_reg(REN_M,  4'h5);
      load_reg(REN_I,  4'h6);
      dm         = 4'h7;
      source_sel = SRC_DM;
      reg_en     = '0;
      reg_en[REN_O_REG] = 1'b1;
      cyc();
      bo = 4'h7;
      source_sel = SRC_PM;
      pm_data    = 4'hB;
      reg_en     = '0;
      reg_en[REN_UNUSED] = 1'b1;
      cyc();
      reg_en = '0;
      checks++;
      if ({x0, x1, y0, y1, m, i_val, o_reg, r} !== {bx0, bx1, by0, by1, bm, bi, bo, mst.r}) begin
         errors++;
         $display("FAIL reg_file: got %h expected %h", {x0, x1, y0, y1, m, i_val, o_reg, r},
                  {bx0, bx1, by0, by1, bm, bi, bo, mst.r});
      end
      i_pins  = 4'h9;
      pm_data = 4'hA;
      for (int s = 0; s < 16; s++) begin
         source_sel = 4'(s);
         #1;
         case (s)
            0: want = bx0;
            1: want = bx1;
            2: want = by0;
            3: want = by1;
            4: want = mst.r;
            5: want = bm;
            6: want = bi;
            7: want = 4'h7;
            8: want = 4'hA;
            9: want = 4'h9;
            default: want = '0;
         endcase
         checks++;
         if (data_bus !== want) begin
            errors++; $display("FAIL bus_src%0d: got %h expected %h", s, data_bus, want);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      pm_data = '0;
      dm      = '0;
      i_pins  = '0;
      drive_idle();
      reset_model();
      test_reset();
      test_alu();
      test_back_to_back();
      test_mul();
      test_nop();
      test_index();
      test_bus();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
